// File: rtl/line_raster_display_if.sv
// Line-drawing request channel: a shape source (master) hands endpoints and colour to the
// raster drawer (slave), which reports busy/done back.
interface line_raster_display_if #(
  parameter int unsigned XY_BITW = 11,
  parameter int unsigned COLORW  = 3
) ();
  logic               line_start;
  logic [XY_BITW-1:0] line_x0;
  logic [XY_BITW-1:0] line_y0;
  logic [XY_BITW-1:0] line_x1;
  logic [XY_BITW-1:0] line_y1;
  logic [COLORW-1:0]  line_color;
  logic               line_oe;
  logic               line_busy;
  logic               line_done;

  modport master (
    output line_start, line_x0, line_y0, line_x1, line_y1, line_color, line_oe,
    input  line_busy, line_done
  );

  modport slave (
    input  line_start, line_x0, line_y0, line_x1, line_y1, line_color, line_oe,
    output line_busy, line_done
  );
endinterface

// File: rtl/line_raster_display.sv
// VGA timing generator, Bresenham line drawer and small dual-port framebuffer scanned out
// as 1-bit R/G/B inside a fixed screen window.
module line_raster_display #(
  parameter int unsigned XY_BITW = 11,
  parameter int unsigned H_RES   = 800,
  parameter int unsigned H_FP    = 40,
  parameter int unsigned H_SP    = 128,
  parameter int unsigned H_BP    = 88,
  parameter bit          H_POL   = 1'b1,
  parameter int unsigned V_RES   = 600,
  parameter int unsigned V_FP    = 1,
  parameter int unsigned V_SP    = 4,
  parameter int unsigned V_BP    = 23,
  parameter bit          V_POL   = 1'b1,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned HEIGHT  = 16,
  parameter int unsigned COLORW  = 3,
  parameter int unsigned POSX    = 0,
  parameter int unsigned POSY    = 0
) (
  input  logic                   clk_pix,
  input  logic                   rst,
  line_raster_display_if.slave   line,
  output logic [XY_BITW-1:0]     sx,
  output logic [XY_BITW-1:0]     sy,
  output logic                   frame,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_de,
  output logic                   vga_r,
  output logic                   vga_g,
  output logic                   vga_b
);

  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SP + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SP + V_BP;
  localparam int unsigned Depth   = WIDTH * HEIGHT;
  localparam int unsigned AddrW   = (Depth > 1) ? $clog2(Depth) : 1;
  // Two spare bits beyond the sign keep 2*err from overflowing.
  localparam int unsigned SW      = XY_BITW + 3;

  typedef logic [XY_BITW-1:0]   coord_t;
  typedef logic signed [SW-1:0] scoord_t;
  typedef enum logic [0:0] {StIdle, StDraw} state_e;

  localparam scoord_t WidthS  = scoord_t'(WIDTH);
  localparam scoord_t HeightS = scoord_t'(HEIGHT);

  // ---------------- display timing ----------------
  coord_t sx_q, sx_d, sy_q, sy_d;

  always_comb begin
    sx_d = sx_q + 1'b1;
    sy_d = sy_q;
    if (sx_q == coord_t'(H_TOTAL - 1)) begin
      sx_d = '0;
      sy_d = (sy_q == coord_t'(V_TOTAL - 1)) ? '0 : sy_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign frame = (sx_q == '0) && (sy_q == '0);

  logic             de_raw, hs_raw, vs_raw, in_win;
  coord_t           fx, fy;
  logic [AddrW-1:0] raddr;

  always_comb begin
    de_raw = (sx_q < coord_t'(H_RES)) && (sy_q < coord_t'(V_RES));
    hs_raw = ((sx_q >= coord_t'(H_RES + H_FP)) && (sx_q < coord_t'(H_RES + H_FP + H_SP)))
             ? H_POL : ~H_POL;
    vs_raw = ((sy_q >= coord_t'(V_RES + V_FP)) && (sy_q < coord_t'(V_RES + V_FP + V_SP)))
             ? V_POL : ~V_POL;
    // Left/above the window the subtraction wraps to a large value and fails the bound test.
    fx     = sx_q - coord_t'(POSX);
    fy     = sy_q - coord_t'(POSY);
    in_win = de_raw && (fx < coord_t'(WIDTH)) && (fy < coord_t'(HEIGHT));
    raddr  = AddrW'(32'(fy) * WIDTH + 32'(fx));
  end

  // ---------------- drawer FSM ----------------
  state_e state_q, state_d;

  scoord_t           x_q, y_q, x1_q, y1_q, dx_q, dy_q, err_q, xstep_q, ystep_q;
  logic [COLORW-1:0] color_q;
  logic              done_q;

  scoord_t xs0, ys0, xs1, ys1, adx, ady, e2, x_n, y_n, err_n;
  logic    at_end, draw, start_acc, step, wr_en;
  logic [AddrW-1:0] waddr;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (line.line_start) state_d = StDraw;
      StDraw: if (line.line_oe && at_end) state_d = StIdle;
    endcase
  end

  always_comb begin
    draw           = (state_q == StDraw);
    start_acc      = (state_q == StIdle) && line.line_start;
    step           = draw && line.line_oe && !at_end;
    wr_en          = draw && line.line_oe && !rst && (x_q < WidthS) && (y_q < HeightS);
    line.line_busy = draw;
    line.line_done = done_q;
  end

  // Bresenham step arithmetic
  always_comb begin
    xs0    = scoord_t'(line.line_x0);
    ys0    = scoord_t'(line.line_y0);
    xs1    = scoord_t'(line.line_x1);
    ys1    = scoord_t'(line.line_y1);
    adx    = (xs1 >= xs0) ? xs1 - xs0 : xs0 - xs1;
    ady    = (ys1 >= ys0) ? ys1 - ys0 : ys0 - ys1;
    at_end = (x_q == x1_q) && (y_q == y1_q);
    e2     = err_q <<< 1;
    x_n    = x_q;
    y_n    = y_q;
    err_n  = err_q;
    if (e2 >= dy_q) begin
      err_n = err_n + dy_q;
      x_n   = x_q + xstep_q;
    end
    if (e2 <= dx_q) begin
      err_n = err_n + dx_q;
      y_n   = y_q + ystep_q;
    end
    waddr  = AddrW'(32'(y_q) * WIDTH + 32'(x_q));
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= draw && line.line_oe && at_end;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (start_acc) begin
      x_q     <= xs0;
      y_q     <= ys0;
      x1_q    <= xs1;
      y1_q    <= ys1;
      dx_q    <= adx;
      dy_q    <= -ady;
      err_q   <= adx - ady;
      xstep_q <= (xs0 < xs1) ? scoord_t'(1) : scoord_t'(-1);
      ystep_q <= (ys0 < ys1) ? scoord_t'(1) : scoord_t'(-1);
      color_q <= line.line_color;
    end else if (step) begin
      x_q   <= x_n;
      y_q   <= y_n;
      err_q <= err_n;
    end
  end

  // ---------------- framebuffer and scan-out ----------------
  logic [COLORW-1:0] mem [Depth];
  logic [COLORW-1:0] rd_q;
  logic              win_q, de_q, hs_q, vs_q;

  // Read-before-write: a same-address access in one cycle returns the old pixel.
  always_ff @(posedge clk_pix) begin
    rd_q <= mem[raddr];
    if (wr_en) begin
      mem[waddr] <= color_q;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      win_q <= 1'b0;
      de_q  <= 1'b0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
    end else begin
      win_q <= in_win;
      de_q  <= de_raw;
      hs_q  <= hs_raw;
      vs_q  <= vs_raw;
    end
  end

  assign vga_de = de_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_r  = win_q & rd_q[2];
  assign vga_g  = win_q & rd_q[1];
  assign vga_b  = win_q & rd_q[0];

endmodule

// File: tb/tb_line_raster_display.sv
// Bench for line_raster_display: per-cycle timing/scan-out reference plus directed and random
// lines checked against a framebuffer model.
module tb_line_raster_display;
  localparam int XYW  = 11;
  localparam int HR   = 40;
  localparam int HFP  = 4;
  localparam int HSP  = 8;
  localparam int HBP  = 6;
  localparam bit HPOL = 1'b0;
  localparam int VR   = 30;
  localparam int VFP  = 1;
  localparam int VSP  = 2;
  localparam int VBP  = 3;
  localparam bit VPOL = 1'b1;
  localparam int W    = 16;
  localparam int H    = 16;
  localparam int PX   = 3;
  localparam int PY   = 2;
  localparam int HT   = HR + HFP + HSP + HBP;
  localparam int VT   = VR + VFP + VSP + VBP;
  localparam int FT   = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_raster_display_if #(.XY_BITW(XYW), .COLORW(3)) lif ();

  logic [XYW-1:0] sx, sy;
  logic frame, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b;

  line_raster_display #(
    .XY_BITW(XYW), .H_RES(HR), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP), .H_POL(HPOL),
    .V_RES(VR), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP), .V_POL(VPOL),
    .WIDTH(W), .HEIGHT(H), .COLORW(3), .POSX(PX), .POSY(PY)
  ) dut (
    .clk_pix(clk), .rst(rst), .line(lif), .sx(sx), .sy(sy), .frame(frame),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit pix_chk = 1'b0;
  logic [2:0] fbm [W*H];

  typedef struct {
    int x0; int y0; int x1; int y1;
    logic [2:0] c;
    logic [7:0] pat;
    bit restart;
    int busy;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference plot following the Bresenham rules; only the first maxpix pixels land.
  function automatic int plot(input int x0, input int y0, input int x1, input int y1,
                              input logic [2:0] c, input int maxpix);
    int dx, dy, sxs, sys, err, e2, x, y, n;
    dx = iabs(x1 - x0); dy = -iabs(y1 - y0);
    sxs = (x0 < x1) ? 1 : -1; sys = (y0 < y1) ? 1 : -1;
    err = dx + dy; x = x0; y = y0; n = 0;
    while (n < 256) begin
      if (n < maxpix && x >= 0 && x < W && y >= 0 && y < H) fbm[y*W + x] = c;
      n++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sxs; end
      if (e2 <= dx) begin err += dx; y += sys; end
    end
    return n;
  endfunction

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Timing and scan-out reference, derived from the elapsed cycle count since reset.
  always @(negedge clk) begin : mon
    int psx, psy;
    bit win;
    if (mon_en) begin
      chk("sx", 32'(sx), cyc % HT);
      chk("sy", 32'(sy), (cyc / HT) % VT);
      chk("frame", 32'(frame), 32'((cyc % FT) == 0));
      if (cyc == 0) begin
        chk("rst_de", 32'(vga_de), 0);
        chk("rst_hs", 32'(vga_hs), 32'(!HPOL));
        chk("rst_vs", 32'(vga_vs), 32'(!VPOL));
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
      end else begin
        psx = (cyc - 1) % HT;
        psy = ((cyc - 1) / HT) % VT;
        chk("de", 32'(vga_de), 32'(psx < HR && psy < VR));
        chk("hs", 32'(vga_hs), 32'((psx >= HR + HFP && psx < HR + HFP + HSP) ? HPOL : !HPOL));
        chk("vs", 32'(vga_vs), 32'((psy >= VR + VFP && psy < VR + VFP + VSP) ? VPOL : !VPOL));
        win = psx < HR && psy < VR && psx >= PX && psx < PX + W && psy >= PY && psy < PY + H;
        if (!win) chk("rgb_outside", 32'({vga_r, vga_g, vga_b}), 0);
        else if (pix_chk)
          chk("rgb_pixel", 32'({vga_r, vga_g, vga_b}), 32'(fbm[(psy - PY)*W + psx - PX]));
      end
    end
  end

  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input logic [2:0] c, input logic [7:0] pat, input bit rnd,
                          input bit restart, input int exp_busy, input string nm);
    int k, writes, npix;
    bit oe;
    npix = imax(iabs(x1 - x0), iabs(y1 - y0)) + 1;
    @(negedge clk);
    lif.line_x0 = XYW'(x0); lif.line_y0 = XYW'(y0);
    lif.line_x1 = XYW'(x1); lif.line_y1 = XYW'(y1);
    lif.line_color = c; lif.line_oe = 1'b1; lif.line_start = 1'b1;
    @(negedge clk);
    lif.line_start = 1'b0;
    k = 0; writes = 0;
    while (lif.line_busy === 1'b1 && k < 200) begin
      oe = rnd ? ($urandom_range(0, 3) != 0) : pat[k % 8];
      if (restart && k == 0) begin
        lif.line_x0 = 9; lif.line_y0 = 9; lif.line_x1 = 9; lif.line_y1 = 9;
        lif.line_color = 3'b111; lif.line_start = 1'b1;
      end else begin
        lif.line_start = 1'b0;
      end
      lif.line_oe = oe;
      writes += int'(oe);
      k++;
      @(negedge clk);
    end
    lif.line_start = 1'b0;
    lif.line_oe = 1'b1;
    if (exp_busy >= 0) chk({nm, "_busy_cycles"}, k, exp_busy);
    chk({nm, "_pixels"}, writes, npix);
    chk({nm, "_done"}, 32'(lif.line_done), 1);
    @(negedge clk);
    chk({nm, "_done_clear"}, 32'(lif.line_done), 0);
    chk({nm, "_idle"}, 32'(lif.line_busy), 0);
    void'(plot(x0, y0, x1, y1, c, npix));
  endtask

  task automatic scan_frame();
    repeat (2) @(negedge clk);
    pix_chk = 1'b1;
    repeat (FT + 2) @(negedge clk);
    pix_chk = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nfr, nde, nhs, k;
    lif.line_start = 1'b0; lif.line_oe = 1'b1; lif.line_color = '0;
    lif.line_x0 = '0; lif.line_y0 = '0; lif.line_x1 = '0; lif.line_y1 = '0;
    for (int i = 0; i < W*H; i++) fbm[i] = '0;

    tbl[0] = '{0, 3, 9, 3, 3'b100, 8'hFF, 1'b0, 10};
    tbl[1] = '{15, 0, 0, 15, 3'b011, 8'hFF, 1'b0, 16};
    tbl[2] = '{5, 5, 5, 5, 3'b110, 8'hFF, 1'b1, 1};
    tbl[3] = '{0, 0, 4, 2, 3'b101, 8'h55, 1'b0, 9};
    tbl[4] = '{12, 2, 12, 9, 3'b010, 8'hFF, 1'b0, 8};
    tbl[5] = '{14, 12, 18, 14, 3'b111, 8'hFF, 1'b0, 5};
    tbl[6] = '{2, 14, 10, 11, 3'b001, 8'b0011_0111, 1'b0, 13};

    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(lif.line_busy), 0);
    chk("rst_done", 32'(lif.line_done), 0);
    rst = 1'b0;

    // Two frames of timing
    nfr = 0; nde = 0; nhs = 0;
    repeat (2 * FT) begin
      @(negedge clk);
      nfr += int'(frame);
      nde += int'(vga_de);
      nhs += int'(vga_hs == HPOL);
    end
    chk("frame_pulses", nfr, 2);
    chk("de_count", nde, 2 * HR * VR);
    chk("hs_active_count", nhs, 2 * VT * HSP);

    // Framebuffer initialised to a known colour by drawing every row
    for (int y = 0; y < H; y++) run_line(0, y, W - 1, y, 3'b000, 8'hFF, 1'b0, 1'b0, W, "clr");

    for (int i = 0; i < 7; i++)
      run_line(tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].c, tbl[i].pat, 1'b0,
               tbl[i].restart, tbl[i].busy, $sformatf("vec%0d", i));
    scan_frame();

    for (int i = 0; i < 25; i++)
      run_line($urandom_range(0, 19), $urandom_range(0, 19), $urandom_range(0, 19),
               $urandom_range(0, 19), 3'($urandom_range(0, 7)), 8'hFF, 1'b1, 1'b0, -1, "rnd");
    scan_frame();

    // Reset in the middle of a line: first five pixels stay, no done pulse
    @(negedge clk);
    lif.line_x0 = 0; lif.line_y0 = 15; lif.line_x1 = 15; lif.line_y1 = 15;
    lif.line_color = 3'b111; lif.line_oe = 1'b1; lif.line_start = 1'b1;
    @(negedge clk);
    lif.line_start = 1'b0;
    k = 0;
    while (lif.line_busy === 1'b1 && k < 5) begin
      k++;
      @(negedge clk);
    end
    chk("midrst_busy_before", 32'(lif.line_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(lif.line_busy), 0);
    chk("midrst_done", 32'(lif.line_done), 0);
    @(negedge clk);
    chk("midrst_done_hold", 32'(lif.line_done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_done_after", 32'(lif.line_done), 0);
    chk("midrst_busy_after", 32'(lif.line_busy), 0);
    void'(plot(0, 15, 15, 15, 3'b111, 5));
    scan_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
